// File: rtl/alu_operand_decoder.sv
// -----------------------------------------------------------------------------
// alu_operand_decoder
//
// Decode-and-issue stage in front of the ALU operand mux. Fetch hands over
// 9-bit instructions on a valid/ready handshake. Each legal instruction is
// decoded into its operand mux select, immediates and register addresses.
// The decoded op is then buffered in a small FIFO that the ALU drains over a
// second valid/ready handshake. Illegal opcodes (111) are accepted and
// dropped, and they are counted in a saturating counter.
//
// Parameters:
//   DEPTH          decoded-op FIFO entries (power of two, >= 2)
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rst_n          synchronous active-low reset
//   flush          synchronous clear of the FIFO contents
//   in_valid       fetch presents an instruction
//   in_instr[8:0]  instruction: op [8:6], rd [5:3], rs/imm [2:0]
//   in_ready       stage can accept an instruction this cycle
//   out_valid      head entry valid
//   out_ready      ALU consumes the head entry this cycle
//   alu_op[2:0]    opcode field of the head entry
//   src_sel[1:0]   operand mux select: 0 reg, 1 lsr imm, 2 dump (r0), 3 const 1
//   lsr_imm[2:0]   shift immediate
//   bit_1          constant-one bit
//   rd_addr[2:0]   destination register
//   rs_addr[2:0]   source register read address
//   wr_en          result is written to rd
//   illegal_pulse  one-cycle pulse after an illegal instruction is accepted
//   illegal_count  saturating count of illegal instructions (not flushed)
// -----------------------------------------------------------------------------
module alu_operand_decoder #(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       in_valid,
    input  logic [8:0] in_instr,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] alu_op,
    output logic [1:0] src_sel,
    output logic [2:0] lsr_imm,
    output logic       bit_1,
    output logic [2:0] rd_addr,
    output logic [2:0] rs_addr,
    output logic       wr_en,
    output logic       illegal_pulse,
    output logic [7:0] illegal_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_AND1 = 3'b011,
        OP_LSR  = 3'b100,
        OP_LSL  = 3'b101,
        OP_DMP  = 3'b110,
        OP_ILL  = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        SRC_REG   = 2'd0,
        SRC_IMM   = 2'd1,
        SRC_DUMP  = 2'd2,
        SRC_CONST = 2'd3
    } src_sel_e;

    typedef struct packed {
        logic [2:0] alu_op;
        logic [1:0] src_sel;
        logic [2:0] lsr_imm;
        logic       bit_1;
        logic [2:0] rd_addr;
        logic [2:0] rs_addr;
        logic       wr_en;
    } entry_t;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    entry_t           mem [DEPTH];
    entry_t           dec;
    entry_t           head;

    opcode_e op;
    logic    is_illegal;
    logic    accept;
    logic    push;
    logic    pop;
    logic    illegal_acc;

    assign op          = opcode_e'(in_instr[8:6]);
    assign is_illegal  = (op == OP_ILL);

    // Ready is a function of reset and occupancy only; a pop in the same
    // cycle never frees a slot for a push when full.
    assign in_ready    = rst_n & (count < FULL_COUNT);
    assign out_valid   = (count != '0);

    assign accept      = in_valid & in_ready;
    assign push        = accept & ~is_illegal;
    assign illegal_acc = accept & is_illegal;
    assign pop         = out_valid & out_ready;

    // Instruction decode.
    always_comb begin
        // NOTE: every field gets a default before the case so no path leaves
        // a variable unassigned, which would infer a latch.
        dec         = '0;
        dec.alu_op  = in_instr[8:6];
        dec.rd_addr = in_instr[5:3];
        dec.wr_en   = 1'b1;
        unique case (op)
            OP_ADD, OP_SUB, OP_AND: begin
                dec.src_sel = SRC_REG;
                dec.rs_addr = in_instr[2:0];
            end
            OP_AND1, OP_LSL: begin
                dec.src_sel = SRC_CONST;
                dec.bit_1   = 1'b1;
            end
            OP_LSR: begin
                dec.src_sel = SRC_IMM;
                dec.lsr_imm = in_instr[2:0];
            end
            OP_DMP: begin
                // Dump always reads r0 through the regfile port.
                dec.src_sel = SRC_DUMP;
            end
            OP_ILL: begin
                // Never written to the FIFO.
                dec.wr_en = 1'b0;
            end
        endcase
    end

    // FIFO storage.
    // NOTE: the entry array has no reset; nothing reads it while out_valid is
    // low, so clearing it would only cost flops.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= dec;
        end
    end

    // Pointers, occupancy and illegal-instruction bookkeeping.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            illegal_pulse <= 1'b0;
            illegal_count <= '0;
        end else begin
            // Illegal accounting is independent of flush.
            illegal_pulse <= illegal_acc;
            if (illegal_acc && (illegal_count != 8'hFF)) begin
                illegal_count <= illegal_count + 8'd1;
            end

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                // Pointers wrap naturally since DEPTH is a power of two.
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Head entry drives the outputs; forced to zero when nothing is valid.
    assign head    = out_valid ? mem[rd_ptr] : '0;
    assign alu_op  = head.alu_op;
    assign src_sel = head.src_sel;
    assign lsr_imm = head.lsr_imm;
    assign bit_1   = head.bit_1;
    assign rd_addr = head.rd_addr;
    assign rs_addr = head.rs_addr;
    assign wr_en   = head.wr_en;

endmodule

// File: tb/tb_alu_operand_decoder.sv
module tb_alu_operand_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic [8:0] in_instr;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] alu_op;
    logic [1:0] src_sel;
    logic [2:0] lsr_imm;
    logic       bit_1;
    logic [2:0] rd_addr;
    logic [2:0] rs_addr;
    logic       wr_en;
    logic       illegal_pulse;
    logic [7:0] illegal_count;

    int n_checks = 0;
    int n_fail   = 0;

    alu_operand_decoder #(.DEPTH(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_instr      (in_instr),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .alu_op        (alu_op),
        .src_sel       (src_sel),
        .lsr_imm       (lsr_imm),
        .bit_1         (bit_1),
        .rd_addr       (rd_addr),
        .rs_addr       (rs_addr),
        .wr_en         (wr_en),
        .illegal_pulse (illegal_pulse),
        .illegal_count (illegal_count)
    );

    always #5 clk = ~clk;

    // Observed head bundle: {out_valid, alu_op, src_sel, lsr_imm, bit_1, rd, rs, wr_en}
    logic [16:0] obs;
    assign obs = {out_valid, alu_op, src_sel, lsr_imm, bit_1, rd_addr, rs_addr, wr_en};

    // ---------------- reference model ----------------
    logic [8:0] q[$];          // accepted legal instructions, oldest first
    int         m_ill_cnt = 0;
    bit         m_pulse   = 0;

    // Expected head bundle straight from the instruction-set table.
    function automatic logic [16:0] exp_out();
        logic [8:0] i;
        int op;
        logic [1:0] s;
        logic [2:0] rs, imm;
        logic b1;
        if (q.size() == 0) return '0;
        i  = q[0];
        op = int'(i[8:6]);
        if (op <= 2)                  s = 2'd0;
        else if (op == 4)             s = 2'd1;
        else if (op == 6)             s = 2'd2;
        else                          s = 2'd3;
        rs  = (op <= 2) ? i[2:0] : 3'd0;
        imm = (op == 4) ? i[2:0] : 3'd0;
        b1  = (op == 3 || op == 5);
        return {1'b1, i[8:6], s, imm, b1, i[5:3], rs, 1'b1};
    endfunction

    function automatic bit exp_ready();
        return (rst_n === 1'b1) && (q.size() < 2);
    endfunction

    function automatic logic [8:0] rand_legal();
        logic [8:0] v;
        v = 9'($urandom);
        v[8:6] = 3'($urandom_range(0, 6));
        return v;
    endfunction

    // One clock cycle: the model applies the handshake seen with the current inputs.
    task automatic tick();
        bit acc, ill, pp;
        #1;
        acc = (in_valid === 1'b1) && exp_ready();
        ill = acc && (in_instr[8:6] == 3'b111);
        pp  = (q.size() > 0) && (out_ready === 1'b1);
        @(posedge clk);
        #1;
        if (rst_n !== 1'b1) begin
            q.delete();
            m_ill_cnt = 0;
            m_pulse   = 0;
        end else begin
            m_pulse = ill;
            if (ill && m_ill_cnt < 255) m_ill_cnt++;
            if (flush === 1'b1) q.delete();
            else begin
                if (pp) void'(q.pop_front());
                if (acc && !ill) q.push_back(in_instr);
            end
        end
    endtask

    task automatic idle();
        flush = 0; in_valid = 0; in_instr = '0; out_ready = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle();
        rst_n = 0;
        tick(); tick();
        n_checks++;
        if (obs !== 17'd0) begin n_fail++; $display("FAIL reset_outputs got %h exp 0", obs); end
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        n_checks++;
        if (illegal_count !== 8'd0 || illegal_pulse !== 1'b0) begin
            n_fail++; $display("FAIL reset_illegal got cnt=%0d pulse=%b exp 0/0", illegal_count, illegal_pulse);
        end
        rst_n = 1; #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset got %b exp 1", in_ready); end
    endtask

    task automatic test_single_ops();
        logic [8:0]  ops [4] = '{9'b100_101_110, 9'b000_001_010, 9'b110_011_000, 9'b011_100_000};
        logic [16:0] fixed [4] = '{
            {1'b1, 3'b100, 2'd1, 3'd6, 1'b0, 3'd5, 3'd0, 1'b1},
            {1'b1, 3'b000, 2'd0, 3'd0, 1'b0, 3'd1, 3'd2, 1'b1},
            {1'b1, 3'b110, 2'd2, 3'd0, 1'b0, 3'd3, 3'd0, 1'b1},
            {1'b1, 3'b011, 2'd3, 3'd0, 1'b1, 3'd4, 3'd0, 1'b1}};
        for (int k = 0; k < 4; k++) begin
            idle();
            in_valid = 1; in_instr = ops[k];
            tick();
            idle();
            n_checks++;
            if (obs !== fixed[k]) begin n_fail++; $display("FAIL single_op%0d got %h exp %h", k, obs, fixed[k]); end
            n_checks++;
            if (obs !== exp_out()) begin n_fail++; $display("FAIL single_model%0d got %h exp %h", k, obs, exp_out()); end
            out_ready = 1;
            tick();
            idle();
            n_checks++;
            if (obs !== 17'd0) begin n_fail++; $display("FAIL single_pop%0d got %h exp 0", k, obs); end
        end
    endtask

    task automatic test_backpressure();
        logic [8:0] ins [3];
        logic [16:0] held;
        int accepted = 0;
        for (int k = 0; k < 3; k++) ins[k] = rand_legal();
        idle();
        in_valid = 1;
        for (int c = 0; c < 4; c++) begin
            in_instr = ins[accepted < 3 ? accepted : 2];
            #1;
            if (in_ready === 1'b1) accepted++;
            tick();
        end
        n_checks++;
        if (accepted !== 2) begin n_fail++; $display("FAIL bp_accepts got %0d exp 2", accepted); end
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready got %b exp 0", in_ready); end
        held = obs;
        tick();
        n_checks++;
        if (obs !== held || obs !== exp_out()) begin
            n_fail++; $display("FAIL bp_hold got %h exp %h", obs, exp_out());
        end
        // Pop once while the third instruction waits: it cannot enter this cycle.
        out_ready = 1;
        tick();
        out_ready = 0;
        n_checks++;
        if (in_ready !== 1'b1 || q.size() != 1) begin
            n_fail++; $display("FAIL bp_ready_return got %b exp 1", in_ready);
        end
        tick();   // third instruction accepted now
        in_valid = 0;
        out_ready = 1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs !== exp_out() || alu_op !== ins[k+1][8:6] || rd_addr !== ins[k+1][5:3]) begin
                n_fail++; $display("FAIL bp_order%0d got %h exp %h", k, obs, exp_out());
            end
            tick();
        end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained got %b exp 0", out_valid); end
        idle();
    endtask

    task automatic test_illegal();
        logic [8:0] seq [4];
        logic [8:0] legal;
        int pulses = 0;
        int start = m_ill_cnt;
        legal = rand_legal();
        seq = '{9'b111_000_000, legal, 9'b111_000_000, 9'b111_000_000};
        idle();
        for (int k = 0; k < 4; k++) begin
            in_valid = 1; in_instr = seq[k];
            tick();
            if (illegal_pulse === 1'b1) pulses++;
        end
        idle();
        for (int k = 0; k < 2; k++) begin
            tick();
            if (illegal_pulse === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses !== 3) begin n_fail++; $display("FAIL ill_pulses got %0d exp 3", pulses); end
        n_checks++;
        if (illegal_count !== 8'(start + 3)) begin
            n_fail++; $display("FAIL ill_count got %0d exp %0d", illegal_count, start + 3);
        end
        n_checks++;
        if (obs !== exp_out() || alu_op !== legal[8:6] || q.size() != 1) begin
            n_fail++; $display("FAIL ill_only_legal got %h exp %h", obs, exp_out());
        end
        out_ready = 1; tick();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ill_one_entry got %b exp 0", out_valid); end
        idle();
        in_valid = 1; in_instr = 9'b111_000_000;
        for (int k = 0; k < 300; k++) begin
            in_instr[5:0] = 6'($urandom);
            tick();
        end
        idle();
        tick();
        n_checks++;
        if (illegal_count !== 8'd255 || m_ill_cnt != 255) begin
            n_fail++; $display("FAIL ill_saturate got %0d exp 255", illegal_count);
        end
    endtask

    task automatic test_flush();
        idle();
        rst_n = 0; tick(); rst_n = 1;
        // Illegal accepted during flush still counts.
        flush = 1; in_valid = 1; in_instr = 9'b111_010_001;
        tick();
        idle();
        n_checks++;
        if (illegal_count !== 8'd1 || illegal_pulse !== 1'b1) begin
            n_fail++; $display("FAIL flush_ill got cnt=%0d pulse=%b exp 1/1", illegal_count, illegal_pulse);
        end
        in_valid = 1;
        for (int k = 0; k < 2; k++) begin in_instr = rand_legal(); tick(); end
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL flush_prefill got ready=%b valid=%b exp 0/1", in_ready, out_valid);
        end
        // Flush with a full FIFO, a push attempt and a pop attempt.
        in_instr = rand_legal(); flush = 1; out_ready = 1;
        tick();
        idle();
        n_checks++;
        if (obs !== 17'd0 || in_ready !== 1'b1 || illegal_count !== 8'(m_ill_cnt)) begin
            n_fail++; $display("FAIL flush_clear got %h rdy=%b cnt=%0d exp 0/1/%0d", obs, in_ready, illegal_count, m_ill_cnt);
        end
        // Flush while not full: concurrent push must still be lost.
        in_valid = 1; in_instr = rand_legal(); tick();
        in_instr = rand_legal(); flush = 1; tick();
        idle();
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_push_lost got %b exp 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        idle();
        in_valid = 1; in_instr = rand_legal(); tick();
        out_ready = 1;
        for (int k = 0; k < 10; k++) begin
            in_instr = rand_legal();
            tick();
            if (out_valid !== 1'b1 || obs !== exp_out()) begin
                bad++; $display("FAIL b2b_cycle%0d got %h exp %h", k, obs, exp_out());
            end
        end
        n_checks++;
        if (bad != 0) n_fail++;
        in_valid = 0; tick();
        idle();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        idle();
        in_valid = 1;
        for (int k = 0; k < 2; k++) begin in_instr = rand_legal(); tick(); end
        in_instr = 9'b111_000_000; rst_n = 0;
        tick();
        rst_n = 1; idle(); #1;
        n_checks++;
        if (obs !== 17'd0 || illegal_pulse !== 1'b0 || illegal_count !== 8'd0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid got %h pulse=%b cnt=%0d rdy=%b exp 0/0/0/1", obs, illegal_pulse, illegal_count, in_ready);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int c = 0; c < 400; c++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            in_valid  = $urandom_range(0, 1);
            in_instr  = ($urandom_range(0, 7) == 0) ? {3'b111, 6'($urandom)} : rand_legal();
            out_ready = $urandom_range(0, 1);
            #1;
            if (in_ready !== exp_ready()) begin
                bad++; $display("FAIL rand_ready c%0d got %b exp %b", c, in_ready, exp_ready());
            end
            tick();
            if (obs !== exp_out() || illegal_count !== 8'(m_ill_cnt) || illegal_pulse !== m_pulse) begin
                bad++;
                $display("FAIL rand_state c%0d got %h cnt=%0d p=%b exp %h cnt=%0d p=%b",
                         c, obs, illegal_count, illegal_pulse, exp_out(), m_ill_cnt, m_pulse);
            end
        end
        n_checks++;
        if (bad != 0) n_fail++;
        rst_n = 1; idle();
    endtask

    initial begin
        rst_n = 0;
        idle();
        test_reset();
        test_single_ops();
        test_backpressure();
        test_illegal();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_operand_decoder.md
# alu_operand_decoder

Decode-and-issue stage feeding the ALU operand mux. Accepts 9-bit instructions from fetch over a valid/ready handshake, decodes each into the mux select code, the immediates and the register addresses, and buffers up to two decoded ops in a FIFO. The ALU pops these over a second valid/ready handshake. Illegal opcodes are consumed, dropped and counted.

## Interface
Parameters:
- DEPTH, 2, decoded-op FIFO entries (power of two, ≥2)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- flush  input  1  synchronous clear of FIFO contents
- in_valid  input  1  fetch presents instruction
- in_instr  input  9  instruction word
- in_ready  output  1  stage can accept instruction this cycle
- out_valid  output  1  head entry valid
- out_ready  input  1  ALU consumes head entry this cycle
- alu_op  output  3  opcode field of head entry
- src_sel  output  2  operand mux select: 0 reg, 1 lsr imm, 2 dump (r0 low nibble), 3 constant 1
- lsr_imm  output  3  shift immediate
- bit_1  output  1  constant-one bit
- rd_addr  output  3  destination register
- rs_addr  output  3  source register read address
- wr_en  output  1  result written to rd
- illegal_pulse  output  1  one-cycle pulse on illegal accept
- illegal_count  output  8  saturating illegal-instruction count

## Operation
- Fields: op = in_instr[8:6], rd = [5:3], rs/imm = [2:0].
- Decode per op:
  - 000 ADD, 001 SUB, 010 AND: src_sel 0, rs_addr = [2:0], lsr_imm 0, bit_1 0, wr_en 1.
  - 011 AND1: src_sel 3, bit_1 1, rs_addr 0, wr_en 1.
  - 100 LSR: src_sel 1, lsr_imm = [2:0], rs_addr 0, wr_en 1.
  - 101 LSL (shift by one): src_sel 3, bit_1 1, rs_addr 0, wr_en 1.
  - 110 DMP: src_sel 2, rs_addr forced 0 (regfile reads r0), rd = [5:3], wr_en 1.
  - 111 illegal: not written to FIFO.
- rd_addr = [5:3] for every legal op.
- Push: in_valid & in_ready & op≠111 writes the decoded entry at the tail.
- Pop: out_valid & out_ready advances the head.
- Illegal: in_valid & in_ready & op=111 completes the handshake. Asserts illegal_pulse for the next cycle. illegal_count increments, saturating at 255.
- Counter widths: count is log2(DEPTH)+1 bits; pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Flush: pointers and count go to 0 and any simultaneous push or pop is ignored. An illegal instruction accepted in the flush cycle is still counted. illegal_count is not cleared by flush.
- When out_valid = 0, all decoded outputs are driven 0.

## Timing
- Reset (rst_n = 0 at a clock edge):
  - FIFO empty, illegal_count 0, illegal_pulse 0.
  - in_ready is 0 while rst_n is low.
  - out_valid and all decoded outputs are 0.
- in_ready = rst_n & (count < DEPTH). It is combinational from state only and never depends on out_ready, so there is no ready-through path.
- Consequence: when full, a pop and a push cannot occur in the same cycle. The slot frees on the next cycle.
- Latency: an instruction accepted at edge N appears on out_valid and the outputs after edge N; the ALU can consume it at edge N+1.
- Empty FIFO: a push and a pop cannot coincide (out_valid = 0). There is no bypass.
- Outputs are registered from the FIFO head. They hold stable while out_valid & !out_ready.
- Reset asserted mid-stream discards all entries. No partial pulse survives.

## Test plan
- Reset then single ops:
  - LSR r5, 6 (9'b100_101_110) → next cycle out_valid 1, src_sel 1, lsr_imm 6, rd_addr 5, rs_addr 0, wr_en 1.
  - ADD r1, r2 (9'b000_001_010) → src_sel 0, rs_addr 2, lsr_imm 0.
- DMP r3 (9'b110_011_000) → src_sel 2, rs_addr 0, rd_addr 3. AND1 r4 (9'b011_100_000) → src_sel 3, bit_1 1.
- Backpressure:
  - Hold out_ready 0 and push 3 instructions → in_ready drops after 2 accepts, and the third waits.
  - Raise out_ready for 1 cycle → head pops; in_ready returns the following cycle; entries emerge in order.
- Illegal: push 9'b111_000_000 three times, interleaved with a legal op → only the legal op appears, illegal_pulse fires 3 times, illegal_count = 3. Push 300 illegals → illegal_count = 255.
- Flush with 2 entries and concurrent in_valid → next cycle out_valid 0, count 0, the pushed instruction is lost, illegal_count unchanged.
- Simultaneous push/pop with 1 entry for 10 cycles → out_valid stays 1 and the order is preserved.
- rst_n low mid-stream for 1 cycle → all outputs 0, FIFO empty.
